param_fifo: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed 32-entry, single-bit FIFO in the USB serial datapath. It sits between the bit-stuffing/NRZI stages and the packet encoder/decoder. Width, depth and the almost-full/almost-empty thresholds are all configurable, and it adds a synchronous flush and sticky overflow/underflow error flags. It is first-word-fall-through: the head entry is always visible on `dout`.

---
 rtl/param_fifo.sv | 115 +++++++++++
 tb/tb_param_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo.sv
// Parameterised first-word-fall-through synchronous FIFO with an explicit
// occupancy counter. Define PARAM_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module param_fifo #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic             re,
  input  logic             flush,
  input  logic             err_clr,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ok, rd_ok;

  // All status flags decode from the registered count only.
  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign dout         = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when a read frees the slot this cycle.
  assign rd_ok = re & ~empty & ~flush;
  assign wr_ok = we & (~full | re) & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

`ifdef PARAM_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // A new error in the same cycle as err_clr wins over the clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (we & full & ~re & ~flush) ovf_d = 1'b1;
    if (re & empty & ~flush)      unf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench: two FIFO instances (DEPTH 4 and DEPTH 8) share one
// stimulus stream and are compared against queue-based reference models.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0, re = 1'b0, flush = 1'b0, err_clr = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] dout4, dout8;
  logic [2:0] count4;
  logic [3:0] count8;
  logic       full4, empty4, af4, ae4, ov4, un4;
  logic       full8, empty8, af8, ae8, ov8, un8;

  int checks = 0;
  int errors = 0;

  typedef logic [7:0] byte_q_t[$];
  byte_q_t mq [2];
  bit      m_ov [2];
  bit      m_un [2];

`ifdef PARAM_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .flush(flush),
    .err_clr(err_clr), .dout(dout4), .full(full4), .empty(empty4),
    .almost_full(af4), .almost_empty(ae4), .count(count4),
    .overflow(ov4), .underflow(un4));

  param_fifo #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u8 (
    .clk(clk), .rst(rst), .we(we), .din(din), .re(re), .flush(flush),
    .err_clr(err_clr), .dout(dout8), .full(full8), .empty(empty8),
    .almost_full(af8), .almost_empty(ae8), .count(count8),
    .overflow(ov8), .underflow(un8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n4, n8;
    n4 = mq[0].size();
    n8 = mq[1].size();
    chk("count4", 32'(count4), n4);
    chk("empty4", 32'(empty4), 32'(n4 == 0));
    chk("full4",  32'(full4),  32'(n4 == 4));
    chk("ae4",    32'(ae4),    32'(n4 <= 2));
    chk("af4",    32'(af4),    32'(n4 >= 2));
    chk("ov4",    32'(ov4),    32'(m_ov[0]));
    chk("un4",    32'(un4),    32'(m_un[0]));
    if (n4 > 0) chk("dout4", 32'(dout4), 32'(mq[0][0]));
    chk("count8", 32'(count8), n8);
    chk("empty8", 32'(empty8), 32'(n8 == 0));
    chk("full8",  32'(full8),  32'(n8 == 8));
    chk("ae8",    32'(ae8),    32'(n8 <= 2));
    chk("af8",    32'(af8),    32'(n8 >= 6));
    chk("ov8",    32'(ov8),    32'(m_ov[1]));
    chk("un8",    32'(un8),    32'(m_un[1]));
    if (n8 > 0) chk("dout8", 32'(dout8), 32'(mq[1][0]));
  endtask

  // Drive one cycle, advance the reference models at the edge, then check.
  task automatic tick(input bit w, input logic [7:0] d, input bit r,
                      input bit f = 1'b0, input bit ec = 1'b0);
    we = w; din = d; re = r; flush = f; err_clr = ec;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      int dep;
      int n;
      dep = (k == 0) ? 4 : 8;
      n   = mq[k].size();
      if (f) mq[k].delete();
      else begin
        if (r && n > 0) void'(mq[k].pop_front());
        if (w && (n < dep || r)) mq[k].push_back(d);
      end
      if (ERR_EN) begin
        m_ov[k] = (w && n == dep && !r && !f) || (m_ov[k] && !ec);
        m_un[k] = (r && n == 0 && !f) || (m_un[k] && !ec);
      end
    end
    #1;
    we = 1'b0; re = 1'b0; flush = 1'b0; err_clr = 1'b0;
    check_all();
  endtask

  initial begin
    logic [7:0] v;
    // Reset state
    #1;
    chk("rst_count4", 32'(count4), 0);
    chk("rst_empty4", 32'(empty4), 1);
    chk("rst_full4",  32'(full4),  0);
    chk("rst_ae4",    32'(ae4),    1);
    chk("rst_af4",    32'(af4),    0);
    chk("rst_ov4",    32'(ov4),    0);
    chk("rst_un4",    32'(un4),    0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Basic fill and drain
    tick(1, 8'h11, 0); tick(1, 8'h22, 0); tick(1, 8'h33, 0);
    chk("full_before4", 32'(full4), 0);
    tick(1, 8'h44, 0);
    chk("full_after4", 32'(full4), 1);
    v = 8'h11;
    for (int i = 0; i < 4; i++) begin
      chk("drain_dout4", 32'(dout4), 32'(v));
      tick(0, 8'h00, 1);
      v = v + 8'h11;
    end
    chk("drain_empty4", 32'(empty4), 1);

    // Wrap-around
    for (int i = 0; i < 3; i++) tick(1, 8'(i), 0);
    chk("wrap_cnt3", 32'(count4), 3);
    for (int i = 0; i < 3; i++) tick(0, 8'h00, 1);
    chk("wrap_cnt0", 32'(count4), 0);
    for (int i = 0; i < 4; i++) tick(1, 8'hA0 + 8'(i), 0);
    chk("wrap_cnt4", 32'(count4), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_dout4", 32'(dout4), 32'(8'hA0 + 8'(i)));
      tick(0, 8'h00, 1);
    end

    // Simultaneous write+read when full
    tick(0, 8'h00, 0, 1);
    for (int i = 1; i <= 4; i++) tick(1, 8'(i), 0);
    tick(1, 8'h05, 1);
    chk("sim_full_cnt4", 32'(count4), 4);
    for (int i = 2; i <= 5; i++) begin
      chk("sim_full_dout4", 32'(dout4), i);
      tick(0, 8'h00, 1);
    end

    // Simultaneous write+read when empty: no bypass, read underflows
    tick(1, 8'h09, 1);
    chk("sim_empty_cnt4", 32'(count4), 1);
    chk("sim_empty_dout4", 32'(dout4), 32'h09);
    chk("sim_empty_un4", 32'(un4), 32'(ERR_EN));
    tick(0, 8'h00, 0, 0, 1);
    chk("un_clr4", 32'(un4), 0);

    // Overflow on the DEPTH-4 instance, sticky until err_clr
    for (int i = 0; i < 3; i++) tick(1, 8'hB0 + 8'(i), 0);
    tick(1, 8'hEE, 0);
    chk("ovf_set4", 32'(ov4), 32'(ERR_EN));
    chk("ovf_head4", 32'(dout4), 32'h09);
    tick(0, 8'h00, 0);
    chk("ovf_hold4", 32'(ov4), 32'(ERR_EN));
    tick(0, 8'h00, 0, 0, 1);
    chk("ovf_clr4", 32'(ov4), 0);
    tick(1, 8'hEF, 0, 0, 1);
    chk("ovf_setwins4", 32'(ov4), 32'(ERR_EN));

    // Thresholds on the DEPTH-8 instance
    tick(0, 8'h00, 0, 1, 1);
    for (int i = 1; i <= 7; i++) begin
      tick(1, 8'(i), 0);
      chk("thr_ae8", 32'(ae8), 32'(i <= 2));
      chk("thr_af8", 32'(af8), 32'(i >= 6));
    end

    // Flush with write at count 3
    tick(0, 8'h00, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(1, 8'(i), 0);
    tick(1, 8'h77, 0, 1);
    chk("flush_cnt4", 32'(count4), 0);
    chk("flush_empty4", 32'(empty4), 1);
    chk("flush_ov4", 32'(ov4), 0);

    // Asynchronous reset mid-burst
    tick(1, 8'h51, 0); tick(1, 8'h52, 0);
    we = 1'b1; din = 8'h53;
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete(); m_ov[k] = 1'b0; m_un[k] = 1'b0;
    end
    chk("arst_cnt4", 32'(count4), 0);
    chk("arst_empty8", 32'(empty8), 1);
    check_all();
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;

    // Randomised traffic against the models
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
